// File: rtl/opcode_decode_pipe_pkg.sv
// Package opcode_type: shared types and encodings for opcode_decode_pipe.
//   opcode_t         - decoded instruction class, including unknown_type
//   OP_*             - the eleven 7-bit major opcode encodings
//   decoded_bundle_t - one decoded lane as stored in the output FIFO
// Optional feature macro: DECODE_ILLEGAL_EN adds the per-lane illegal flag
// to decoded_bundle_t. Without it, no illegal storage exists.
package opcode_type;

  typedef enum logic [3:0] {
    lui,
    auipc,
    jal,
    jalr,
    branch_type,
    load_type,
    store_type,
    imm_arith_type,
    reg_arith_type,
    fence_type,
    system_type,
    unknown_type
  } opcode_t;

  localparam logic [6:0] OP_LUI       = 7'b0110111;
  localparam logic [6:0] OP_AUIPC     = 7'b0010111;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_IMM_ARITH = 7'b0010011;
  localparam logic [6:0] OP_REG_ARITH = 7'b0110011;
  localparam logic [6:0] OP_FENCE     = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM    = 7'b1110011;

  // One lane of a decoded bundle. A bundle is an array of these, LANES wide.
  typedef struct packed {
    opcode_t op_class;
    logic    lane_valid;
`ifdef DECODE_ILLEGAL_EN
    logic    illegal;
`endif
  } decoded_bundle_t;

endpackage

// File: rtl/opcode_decode_pipe_lane_dec.sv
// opcode_lane_dec: combinational decode of one fetched instruction lane.
//   instr      - 32-bit fetched instruction
//   lane_valid - lane occupancy bit
//   op_class   - decoded class (unknown_type for empty lanes)
//   illegal    - illegal-encoding flag; constant 0 unless DECODE_ILLEGAL_EN
module opcode_lane_dec
  import opcode_type::*;
(
  input  logic [31:0] instr,
  input  logic        lane_valid,
  output opcode_t     op_class,
  output logic        illegal
);

  // Only the major opcode field is decoded.
  logic unused_hi;
  assign unused_hi = ^instr[31:7];

  opcode_t table_class;

  always_comb begin
    table_class = unknown_type;
    case (instr[6:0])
      OP_LUI:       table_class = lui;
      OP_AUIPC:     table_class = auipc;
      OP_JAL:       table_class = jal;
      OP_JALR:      table_class = jalr;
      OP_BRANCH:    table_class = branch_type;
      OP_LOAD:      table_class = load_type;
      OP_STORE:     table_class = store_type;
      OP_IMM_ARITH: table_class = imm_arith_type;
      OP_REG_ARITH: table_class = reg_arith_type;
      OP_FENCE:     table_class = fence_type;
      OP_SYSTEM:    table_class = system_type;
      default:      table_class = unknown_type;
    endcase
  end

  always_comb begin
    op_class = unknown_type;
    illegal  = 1'b0;
    if (lane_valid) begin
      op_class = table_class;
`ifdef DECODE_ILLEGAL_EN
      // Compressed / non-32-bit encodings are not decodable here.
      if (instr[1:0] != 2'b11) op_class = unknown_type;
      illegal = (op_class == unknown_type);
`endif
    end
  end

endmodule

// File: rtl/opcode_decode_pipe.sv
// opcode_decode_pipe: decodes LANES instructions per bundle and buffers the
// decoded bundles in a DEPTH-entry FIFO between fetch and issue.
//   clk, rst                   - clock, asynchronous active-low reset
//   in_valid/in_ready          - fetch-side handshake
//   in_instr, in_lane_valid    - bundle payload, lane i at [32*i+31:32*i]
//   flush                      - drop all buffered and incoming bundles
//   out_valid/out_ready        - issue-side handshake
//   out_opcode_type, out_lane_valid, out_illegal - head bundle fields
//   occupancy                  - number of buffered bundles
// Handshake: a transfer happens on a rising edge where valid && ready and
// flush is low; the producer holds its payload until that edge, and out_*
// payload stays stable while out_valid && !out_ready.
// Optional feature macro: DECODE_ILLEGAL_EN enables illegal-encoding flags.
module opcode_decode_pipe
  import opcode_type::*;
#(
  parameter int LANES = 1,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*32-1:0]        in_instr,
  input  logic [LANES-1:0]           in_lane_valid,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output opcode_t                    out_opcode_type [LANES],
  output logic [LANES-1:0]           out_lane_valid,
  output logic [LANES-1:0]           out_illegal,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  opcode_t         lane_cls [LANES];
  logic            lane_ill [LANES];
  decoded_bundle_t lane_dec [LANES];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    opcode_lane_dec u_dec (
      .instr      (in_instr[32*g +: 32]),
      .lane_valid (in_lane_valid[g]),
      .op_class   (lane_cls[g]),
      .illegal    (lane_ill[g])
    );
  end

`ifndef DECODE_ILLEGAL_EN
  // The decoder's flag is constant 0 in this build and is not stored.
  logic lane_ill_unused;
  always_comb begin
    lane_ill_unused = 1'b0;
    for (int i = 0; i < LANES; i++) lane_ill_unused = lane_ill_unused ^ lane_ill[i];
  end
`endif

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_dec[i].op_class   = lane_cls[i];
      lane_dec[i].lane_valid = in_lane_valid[i];
`ifdef DECODE_ILLEGAL_EN
      lane_dec[i].illegal    = lane_ill[i];
`endif
    end
  end

  decoded_bundle_t   mem [DEPTH][LANES];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              push;
  logic              pop;

  assign in_ready  = rst && (count < CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign occupancy = count;
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset: it is only observed while out_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = 0; i < LANES; i++) mem[wr_ptr][i] <= lane_dec[i];
    end
  end

  // Empty FIFO (including during reset) presents neutral payload values.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      out_opcode_type[i] = unknown_type;
      out_lane_valid[i]  = 1'b0;
`ifdef DECODE_ILLEGAL_EN
      out_illegal[i]     = 1'b0;
`endif
      if (out_valid) begin
        out_opcode_type[i] = mem[rd_ptr][i].op_class;
        out_lane_valid[i]  = mem[rd_ptr][i].lane_valid;
`ifdef DECODE_ILLEGAL_EN
        out_illegal[i]     = mem[rd_ptr][i].illegal;
`endif
      end
    end
  end

`ifndef DECODE_ILLEGAL_EN
  assign out_illegal = '0;
`endif

endmodule

// File: tb/tb_opcode_decode_pipe.sv
// Directed testbench for opcode_decode_pipe (LANES=4, DEPTH=2).
module tb_opcode_decode_pipe;
  import opcode_type::*;

  localparam int LANES = 4;
  localparam int DEPTH = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [LANES*32-1:0]  in_instr;
  logic [LANES-1:0]     in_lane_valid;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  opcode_t              out_opcode_type [LANES];
  logic [LANES-1:0]     out_lane_valid;
  logic [LANES-1:0]     out_illegal;
  logic [1:0]           occupancy;

  int n_checks = 0;
  int n_pass   = 0;

  // clock / reset
  always #5 clk = ~clk;

  opcode_decode_pipe #(.LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_instr        (in_instr),
    .in_lane_valid   (in_lane_valid),
    .flush           (flush),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_opcode_type (out_opcode_type),
    .out_lane_valid  (out_lane_valid),
    .out_illegal     (out_illegal),
    .occupancy       (occupancy)
  );

  // checking
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
  endtask

  task automatic check_head(input string tag, input opcode_t e3, input opcode_t e2,
                            input opcode_t e1, input opcode_t e0,
                            input logic [3:0] mask, input logic [3:0] ill);
    check({tag, ".op0"}, 32'(out_opcode_type[0]), 32'(e0));
    check({tag, ".op1"}, 32'(out_opcode_type[1]), 32'(e1));
    check({tag, ".op2"}, 32'(out_opcode_type[2]), 32'(e2));
    check({tag, ".op3"}, 32'(out_opcode_type[3]), 32'(e3));
    check({tag, ".mask"}, 32'(out_lane_valid), 32'(mask));
    check({tag, ".ill"}, 32'(out_illegal), 32'(ill));
  endtask

  task automatic check_ctl(input string tag, input logic iv, input logic ov, input logic [1:0] occ);
    check({tag, ".in_ready"}, 32'(in_ready), 32'(iv));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    check({tag, ".occ"}, 32'(occupancy), 32'(occ));
  endtask

  // drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bundle(input logic [3:0] mask, input logic [31:0] i3, input logic [31:0] i2,
                            input logic [31:0] i1, input logic [31:0] i0);
    in_lane_valid = mask;
    in_instr      = {i3, i2, i1, i0};
  endtask

  logic [3:0] exp_ill;

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    set_bundle(4'hf, 32'h37, 32'h37, 32'h37, 32'h37);

    // reset held while a bundle is offered
    #1;
    check_ctl("rst0", 1'b0, 1'b0, 2'd0);
    check_head("rst0", unknown_type, unknown_type, unknown_type, unknown_type, 4'h0, 4'h0);
    tick(); tick();
    check_ctl("rst1", 1'b0, 1'b0, 2'd0);
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    check_ctl("rst_rel", 1'b1, 1'b0, 2'd0);

    // single LUI lane, consumed immediately
    set_bundle(4'b0001, 32'h0, 32'h0, 32'h0, 32'h000000B7);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check_ctl("lui", 1'b1, 1'b1, 2'd1);
    check_head("lui", unknown_type, unknown_type, unknown_type, lui, 4'b0001, 4'h0);
    tick();
    check_ctl("lui_pop", 1'b1, 1'b0, 2'd0);

    // fill to full with out_ready low
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_bundle(4'b0011, 32'h0, 32'h0, 32'h00000063, 32'h00000013);
    tick();
    set_bundle(4'b1111, 32'h00000003, 32'h00000017, 32'h00000067, 32'h0000006F);
    tick();
    set_bundle(4'b1111, 32'h37, 32'h37, 32'h37, 32'h37);
    check_ctl("full", 1'b0, 1'b1, 2'd2);
    check_head("full", unknown_type, unknown_type, branch_type, imm_arith_type, 4'b0011, 4'h0);
    tick();
    check_ctl("full_hold", 1'b0, 1'b1, 2'd2);
    check_head("full_hold", unknown_type, unknown_type, branch_type, imm_arith_type, 4'b0011, 4'h0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check_ctl("pop1", 1'b1, 1'b1, 2'd1);
    check_head("pop1", load_type, auipc, jalr, jal, 4'b1111, 4'h0);

    // simultaneous push and pop across the pointer wrap
    in_valid = 1'b1;
    set_bundle(4'b1111, 32'h00000033, 32'h00000073, 32'h0000000F, 32'h00000023);
    tick();
    in_valid = 1'b0;
    check_ctl("pushpop", 1'b1, 1'b1, 2'd1);
    check_head("pushpop", reg_arith_type, system_type, fence_type, store_type, 4'b1111, 4'h0);
    tick();
    check_ctl("drain", 1'b1, 1'b0, 2'd0);

    // lane mask
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_bundle(4'b0101, 32'h33, 32'h33, 32'h33, 32'h33);
    tick();
    check_head("mask", unknown_type, reg_arith_type, unknown_type, reg_arith_type, 4'b0101, 4'h0);

    // flush while full with a bundle offered
    set_bundle(4'b1111, 32'h13, 32'h13, 32'h13, 32'h13);
    tick();
    check_ctl("pre_flush", 1'b0, 1'b1, 2'd2);
    flush = 1'b1;
    set_bundle(4'b1111, 32'h37, 32'h37, 32'h37, 32'h37);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check_ctl("flush", 1'b1, 1'b0, 2'd0);
    tick();
    check_ctl("flush_idle", 1'b1, 1'b0, 2'd0);
    in_valid = 1'b1;
    set_bundle(4'b1111, 32'h17, 32'h17, 32'h17, 32'h17);
    tick();
    in_valid = 1'b0;
    check_ctl("post_flush", 1'b1, 1'b1, 2'd1);
    check_head("post_flush", auipc, auipc, auipc, auipc, 4'b1111, 4'h0);
    out_ready = 1'b1;
    tick();

    // illegal encodings; lane 3 is masked off
`ifdef DECODE_ILLEGAL_EN
    exp_ill = 4'b0011;
`else
    exp_ill = 4'b0000;
`endif
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_bundle(4'b0111, 32'h0000007F, 32'h00000033, 32'h00000036, 32'h0000007F);
    tick();
    in_valid = 1'b0;
    check_head("illegal", unknown_type, reg_arith_type, unknown_type, unknown_type, 4'b0111, exp_ill);
    out_ready = 1'b1;
    tick();
    check_ctl("ill_pop", 1'b1, 1'b0, 2'd0);

    // back-to-back throughput with out_ready high
    in_valid = 1'b1;
    set_bundle(4'b0001, 32'h0, 32'h0, 32'h0, 32'h0000006F);
    tick();
    check_ctl("tp0", 1'b1, 1'b1, 2'd1);
    check("tp0.op0", 32'(out_opcode_type[0]), 32'(jal));
    set_bundle(4'b0001, 32'h0, 32'h0, 32'h0, 32'h00000003);
    tick();
    check_ctl("tp1", 1'b1, 1'b1, 2'd1);
    check("tp1.op0", 32'(out_opcode_type[0]), 32'(load_type));
    set_bundle(4'b0001, 32'h0, 32'h0, 32'h0, 32'h00000023);
    tick();
    check_ctl("tp2", 1'b1, 1'b1, 2'd1);
    check("tp2.op0", 32'(out_opcode_type[0]), 32'(store_type));
    in_valid = 1'b0;
    tick();
    check_ctl("tp_end", 1'b1, 1'b0, 2'd0);

    // asynchronous reset mid-cycle with data buffered
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_bundle(4'b1111, 32'h63, 32'h63, 32'h63, 32'h63);
    tick();
    in_valid = 1'b0;
    check_ctl("pre_arst", 1'b1, 1'b1, 2'd1);
    #2;
    rst = 1'b0;
    #1;
    check_ctl("arst", 1'b0, 1'b0, 2'd0);
    check_head("arst", unknown_type, unknown_type, unknown_type, unknown_type, 4'h0, 4'h0);
    tick();
    rst = 1'b1;
    tick();
    check_ctl("arst_rel", 1'b1, 1'b0, 2'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
